// File: rtl/pixel_mixer_pkg.sv
// pixel_mixer_pkg: shared pixel bundle types and constants
// for the pixel compositor and its sprite picker.
package pixel_mixer_pkg;

  localparam int MIX_PAL_W   = 2;
  localparam int MIX_COLOR_W = 2;

  localparam logic [MIX_COLOR_W-1:0] TRANSPARENT = '0;

  typedef struct packed {
    logic [MIX_PAL_W-1:0]   pal;
    logic [MIX_COLOR_W-1:0] color;
  } bg_pix_t;

  typedef struct packed {
    logic                   behindBg;
    logic [MIX_PAL_W-1:0]   pal;
    logic [MIX_COLOR_W-1:0] color;
  } spr_pix_t;

  typedef struct packed {
    logic                   isSprite;
    logic [MIX_PAL_W-1:0]   pal;
    logic [MIX_COLOR_W-1:0] color;
  } out_pix_t;

endpackage

// File: rtl/pixel_mixer_sprite_select.sv
// sprite_select: combinational picker returning the
// lowest-index opaque sprite channel.
module sprite_select
  import pixel_mixer_pkg::*;
#(
  parameter int NUM_SPR = 8
) (
  input  logic [NUM_SPR*$bits(spr_pix_t)-1:0] spritePixels,
  input  logic [NUM_SPR-1:0]                  opaque,
  output spr_pix_t                            winner,
  output logic                                anyOpaque
);

  localparam int SPR_W = $bits(spr_pix_t);

  // walk downwards so the lowest opaque index is written last
  always_comb begin
    winner    = '0;
    anyOpaque = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        winner    = spr_pix_t'(spritePixels[i*SPR_W +: SPR_W]);
        anyOpaque = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_mixer.sv
// pixel_mixer: 2-stage background/sprite compositor with sprite-0 hit.
// Define MIXER_HIT_CAPTURE_EN to add hitX (x of the first hit).
module pixel_mixer
  import pixel_mixer_pkg::*;
#(
  parameter int NUM_SPR = 8,
  parameter int COLOR_W = MIX_COLOR_W,
  parameter int PAL_W   = MIX_PAL_W,
  parameter int X_W     = 8,
  parameter int CLIP_W  = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 clock_EN,
  input  logic                                 pixelValid_IN,
  input  logic                                 lineStart,
  input  logic                                 backgroundDraw_EN,
  input  logic                                 spriteDraw_EN,
  input  logic                                 backgroundLeft_EN,
  input  logic                                 spriteLeft_EN,
  input  logic [PAL_W+COLOR_W-1:0]             backgroundPixel,
  input  logic [NUM_SPR*(1+PAL_W+COLOR_W)-1:0] spritePixels,
  input  logic                                 sprite0InCh0,
  input  logic                                 clearCollision,
  output logic [PAL_W+COLOR_W:0]               pixel_OUT,
  output logic                                 pixelValid_OUT,
`ifdef MIXER_HIT_CAPTURE_EN
  output logic [X_W-1:0]                       hitX,
`endif
  output logic                                 spriteZeroHit
);

  localparam int SPR_W = 1 + PAL_W + COLOR_W;
  localparam logic [X_W-1:0] X_MAX = '1;
  localparam logic [X_W:0] CLIP_X = (X_W+1)'(CLIP_W);

  logic [X_W-1:0]     xReg;
  logic [X_W-1:0]     dotX;
  logic               inClip;
  logic               bgOpaque;
  logic               hitCand;
  logic               anyOpaque;
  logic [NUM_SPR-1:0] sprOpaque;
  bg_pix_t            bgPix;
  spr_pix_t           winner;

  logic               s1Valid;
  logic               s1BgOpaque;
  logic               s1SprOpaque;
  logic               s1HitCand;
  bg_pix_t            s1Bg;
  spr_pix_t           s1Spr;
  out_pix_t           mixed;
`ifdef MIXER_HIT_CAPTURE_EN
  logic [X_W-1:0]     s1X;
`endif

  assign bgPix  = backgroundPixel;
  assign dotX   = lineStart ? '0 : xReg;
  assign inClip = {1'b0, dotX} < CLIP_X;

  assign bgOpaque = backgroundDraw_EN
                 && (bgPix.color != TRANSPARENT)
                 && !(inClip && !backgroundLeft_EN);

  always_comb begin
    sprOpaque = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      sprOpaque[i] = spriteDraw_EN
                  && (spritePixels[i*SPR_W +: COLOR_W] != TRANSPARENT)
                  && !(inClip && !spriteLeft_EN);
    end
  end

  // the last dot of a saturated line never counts as a hit
  assign hitCand = bgOpaque && sprOpaque[0] && sprite0InCh0
                && (dotX != X_MAX);

  sprite_select #(
    .NUM_SPR (NUM_SPR)
  ) u_sel (
    .spritePixels (spritePixels),
    .opaque       (sprOpaque),
    .winner       (winner),
    .anyOpaque    (anyOpaque)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xReg        <= '0;
      s1Valid     <= 1'b0;
      s1BgOpaque  <= 1'b0;
      s1SprOpaque <= 1'b0;
      s1HitCand   <= 1'b0;
      s1Bg        <= '0;
      s1Spr       <= '0;
`ifdef MIXER_HIT_CAPTURE_EN
      s1X         <= '0;
`endif
    end else if (clock_EN) begin
      s1Valid <= pixelValid_IN;
      if (pixelValid_IN) begin
        xReg        <= (dotX == X_MAX) ? X_MAX : dotX + 1'b1;
        s1BgOpaque  <= bgOpaque;
        s1SprOpaque <= anyOpaque;
        s1HitCand   <= hitCand;
        s1Bg        <= bgPix;
        s1Spr       <= winner;
`ifdef MIXER_HIT_CAPTURE_EN
        s1X         <= dotX;
`endif
      end
    end
  end

  always_comb begin
    mixed = '0;
    unique case (1'b1)
      s1SprOpaque && !(s1BgOpaque && s1Spr.behindBg):
        mixed = {1'b1, s1Spr.pal, s1Spr.color};
      s1BgOpaque && !(s1SprOpaque && !s1Spr.behindBg):
        mixed = {1'b0, s1Bg.pal, s1Bg.color};
      default:
        mixed = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pixel_OUT      <= '0;
      pixelValid_OUT <= 1'b0;
      spriteZeroHit  <= 1'b0;
`ifdef MIXER_HIT_CAPTURE_EN
      hitX           <= '0;
`endif
    end else if (clock_EN) begin
      pixelValid_OUT <= s1Valid;
      pixel_OUT      <= s1Valid ? mixed : '0;
      if (clearCollision) begin
        spriteZeroHit <= 1'b0;
      end else if (s1Valid && s1HitCand) begin
        spriteZeroHit <= 1'b1;
      end
`ifdef MIXER_HIT_CAPTURE_EN
      if (clearCollision) begin
        hitX <= '0;
      end else if (s1Valid && s1HitCand && !spriteZeroHit) begin
        hitX <= s1X;
      end
`endif
    end
  end

endmodule

// File: doc/pixel_mixer.md
# pixel_mixer

Parametrised pixel compositor between the background/sprite pixel generators and the palette lookup. Merges one background pixel with NUM_SPR pre-evaluated sprite channels into a palette index. Adds:
- left-edge clipping from an internal dot counter;
- a two-stage pipeline with valid tracking;
- a sticky sprite-0 hit flag with NES edge rules.

## Interface
Parameters:
- NUM_SPR, 8, sprite channels; channel 0 has the highest priority.
- COLOR_W, 2, colour bits per pixel; colour 0 is transparent.
- PAL_W, 2, palette select bits.
- X_W, 8, dot counter width.
- CLIP_W, 8, width of the left clip region in dots.

Ports:
- clock  in  1  system clock; one clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- clock_EN  in  1  pixel-rate enable; all state advances only when high.
- pixelValid_IN  in  1  current inputs carry a visible dot.
- lineStart  in  1  the current valid dot is x=0.
- backgroundDraw_EN  in  1  background rendering enable.
- spriteDraw_EN  in  1  sprite rendering enable.
- backgroundLeft_EN  in  1  show background in the clip region.
- spriteLeft_EN  in  1  show sprites in the clip region.
- backgroundPixel  in  PAL_W+COLOR_W  {palette, colour}.
- spritePixels  in  NUM_SPR*(1+PAL_W+COLOR_W)  per channel {behindBg, palette, colour}; channel i occupies slice i.
- sprite0InCh0  in  1  channel 0 currently holds OAM sprite 0.
- clearCollision  in  1  clears the hit flag (pre-render line).
- pixel_OUT  out  1+PAL_W+COLOR_W  {isSprite, palette, colour}.
- pixelValid_OUT  out  1  pixel_OUT is valid.
- spriteZeroHit  out  1  sticky sprite-0 hit flag.

## Operation
- Dot counter x: on an enabled cycle with pixelValid_IN high, the current dot uses x=0 if lineStart is high, else x_reg. x_reg then becomes that value +1. x_reg saturates at 2^X_W-1 and does not wrap.
- A dot is in the clip region when x < CLIP_W.
- bgOpaque = backgroundDraw_EN, background colour != 0, and not (clip region and !backgroundLeft_EN).
- sprOpaque[i] = spriteDraw_EN, channel i colour != 0, and not (clip region and !spriteLeft_EN).
- Stage 1, sprite select: the lowest-index opaque channel wins. Its {behindBg, palette, colour} is registered, together with bgOpaque, the background pixel, and hitCand.
- hitCand = bgOpaque, sprOpaque[0], sprite0InCh0, and x != 2^X_W-1. hitCand ignores sprite-versus-background priority and ignores which channel won the select.
- Stage 2, priority:
  - If the background is transparent, output {1, sprite} when a sprite is opaque, else 0.
  - If no sprite is opaque, output {0, background}.
  - If both are opaque, behindBg=0 outputs the sprite and behindBg=1 outputs the background.
  - An all-transparent dot outputs 0, which is the backdrop.
- spriteZeroHit is set when a stage-2 dot with hitCand is valid. It holds until clearCollision or reset.
- clearCollision and a hit in the same enabled cycle: clear wins, and the flag stays 0.

## Timing
- Latency: pixel_OUT and pixelValid_OUT appear 2 enabled cycles after input.
- When clock_EN is low, all registers hold, including the pipeline, the x counter and the flag.
- spriteZeroHit rises in the same enabled cycle that the hitting dot appears on pixel_OUT.
- clearCollision is sampled only when clock_EN is high.
- Reset values: pixel_OUT=0, pixelValid_OUT=0, spriteZeroHit=0, x_reg=0. Both pipeline stages are invalid.
- Reset asserted mid-line flushes both stages immediately. The first valid output after reset comes 2 enabled cycles after the first valid input.
- An invalid input bubble propagates as pixelValid_OUT=0 with pixel_OUT=0. A bubble never sets the flag and never advances x_reg.

## Configuration
- MIXER_HIT_CAPTURE_EN defined:
  - adds output hitX (X_W bits), the x of the first dot that set spriteZeroHit since the last clear;
  - hitX resets to 0 and clears with the flag;
  - hitX is not updated while the flag is already set.
- Undefined: no hitX port and no capture register.

## Structure
- Shared package pixel_mixer_pkg holds:
  - typedefs for the bg pixel, sprite channel, and output pixel structs (parametrised widths passed via localparams);
  - the constant TRANSPARENT=0.
- Sub-module sprite_select: combinational lowest-index opaque-channel picker (NUM_SPR channels). It returns winner data and an anyOpaque bit. It is instantiated in stage 1.

## Test plan
- Priority: bg=5'b0_01_10, ch0={0,01,11}, all enables and left enables on, x=20 -> pixel_OUT=5'b1_01_11 two enabled cycles later. Repeat with behindBg=1 -> 5'b0_01_10.
- Channel select: ch0 colour 0, ch1={0,10,01}, ch3={0,11,11}, bg transparent -> pixel_OUT=5'b1_10_01.
- Clip: backgroundLeft_EN=0, spriteLeft_EN=1, bg and ch0 both opaque:
  - at x=7 -> sprite output, no hit;
  - at x=8 -> normal priority, and the hit sets if ch0 is sprite 0.
- Sprite-0 edge: opaque overlap only at x=255 -> spriteZeroHit stays 0. The same overlap at x=254 -> spriteZeroHit=1, and it stays 1 across following lines until clearCollision.
- Simultaneous events: clearCollision in the same enabled cycle as a hitting dot -> spriteZeroHit=0. A hit on the next dot -> 1. With MIXER_HIT_CAPTURE_EN, hitX equals that dot's x.
- Enable/reset: hold clock_EN low for 5 cycles mid-line -> outputs and x are frozen. Assert reset_n low asynchronously -> all outputs 0 at once, and the first valid output arrives 2 enabled cycles after resumed input.
